// File: rtl/div_pkg.sv
// Shared encodings for the sequential RV32M divider: op codes, FSM states, iteration count.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITERS = DIV_WIDTH;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/div_su32_seq_if.sv
// Request/response bundle between the core pipeline and the sequential divider.
interface div_su32_seq_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;

  modport master (
    output start, op, rs1, rs2,
    input  busy, done, res
  );

  modport slave (
    input  start, op, rs1, rs2,
    output busy, done, res
  );

endinterface

// File: rtl/div_abs_neg.sv
// Conditional two's-complement: out = neg ? -in : in.
module div_abs_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  assign out = neg ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/div_su32_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU with sign fix-up.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish one cycle after accept.
module div_su32_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_ITERS
) (
  input logic           clk,
  input logic           rst,
  div_su32_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifts out of the top, quotient in at the bottom
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             rem_op_q, rem_op_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic             accept, is_signed, is_rem, rs2_zero;
  logic [WIDTH-1:0] abs_rs1, abs_rs2, fix_out;
  logic [WIDTH:0]   trial;

  assign accept    = bus.start && (state_q == S_IDLE || state_q == S_DONE);
  assign is_signed = (bus.op == DIV_OP_DIV) || (bus.op == DIV_OP_REM);
  assign is_rem    = (bus.op == DIV_OP_REM) || (bus.op == DIV_OP_REMU);
  assign rs2_zero  = (bus.rs2 == '0);
  assign trial     = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_rs1 (
    .in  (bus.rs1),
    .neg (is_signed & bus.rs1[WIDTH-1]),
    .out (abs_rs1)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_rs2 (
    .in  (bus.rs2),
    .neg (is_signed & bus.rs2[WIDTH-1]),
    .out (abs_rs2)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_fixup (
    .in  (rem_op_q ? rem_q : quo_q),
    .neg (rem_op_q ? neg_rem_q : neg_quo_q),
    .out (fix_out)
  );

  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    rem_op_d  = rem_op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d   = S_CALC;
          rem_op_d  = is_rem;
          neg_quo_d = is_signed & (bus.rs1[WIDTH-1] ^ bus.rs2[WIDTH-1]) & ~rs2_zero;
          neg_rem_d = is_signed & bus.rs1[WIDTH-1];
          quo_d     = abs_rs1;
          dvs_d     = abs_rs2;
          rem_d     = '0;
          cnt_d     = CntW'(WIDTH - 1);
`ifdef DIV_EARLY_OUT_EN
          if (rs2_zero) begin
            state_d = S_DONE;
            res_d   = is_rem ? bus.rs1 : '1;
          end else if (is_signed && bus.rs1 == {1'b1, {(WIDTH-1){1'b0}}} && bus.rs2 == '1) begin
            state_d = S_DONE;
            res_d   = is_rem ? '0 : bus.rs1;
          end
`endif
        end
      end
      S_CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FIXUP;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      S_FIXUP: begin
        res_d   = fix_out;
        state_d = S_DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      rem_op_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      rem_op_q  <= rem_op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign bus.busy = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign bus.done = (state_q == S_DONE);
  assign bus.res  = res_q;

endmodule

// File: tb/tb_div_su32_seq.sv
// Directed + random bench for div_su32_seq with an expected-result queue; honours DIV_EARLY_OUT_EN.
module tb_div_su32_seq;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_su32_seq_if #(.WIDTH(32)) bus ();

  div_su32_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      DIV_OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      DIV_OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      DIV_OP_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default:     return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return 34;
  endfunction

  // Call right after a negedge; start is sampled on the following posedge (cycle k).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs1   = a;
    bus.rs2   = b;
    exp_q.push_back(exp);
  endtask

  // Negedge n after issue observes cycle k+n; optional start poke at n==poke.
  task automatic wait_done(input string tag, input int lat, input int poke);
    int          got;
    bit          seen;
    logic [31:0] e;
    got  = 0;
    seen = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
      if (poke != 0 && n == poke) begin
        bus.start = 1'b1;
        bus.op    = DIV_OP_DIVU;
        bus.rs1   = 32'h1234_5678;
        bus.rs2   = 32'd3;
      end
      if (poke != 0 && n == poke + 1) bus.start = 1'b0;
      if (n == 1 && lat > 1) check({tag, "_busy_k1"}, 32'(bus.busy), 32'd1);
      if (bus.done) begin
        seen = 1'b1;
        got  = n;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, got, lat);
      check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_res"}, bus.res, e);
      end
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    issue(op, a, b, exp);
    wait_done(tag, lat_of(op, a, b), 0);
  endtask

  initial begin
    bit          seen_done;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.rs1   = '0;
    bus.rs2   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_res", bus.res, 32'd0);
    rst = 1'b0;

    run("div_pos_neg", DIV_OP_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA);
    run("rem_pos_neg", DIV_OP_REM, 32'd20, 32'hFFFF_FFFD, 32'd2);
    run("divu_max", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
    run("rem_neg", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("remu_big", DIV_OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1);
    run("divu_bigdvs", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
    run("remu_bigdvs", DIV_OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
    run("div_by0", DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("remu_by0", DIV_OP_REMU, 32'd5, 32'd0, 32'd5);
    run("rem_neg_by0", DIV_OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run("div_ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem_ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Mid-operation start must not disturb the running divide.
    @(negedge clk);
    issue(DIV_OP_DIVU, 32'd1000, 32'd7, 32'd142);
    wait_done("poke", 34, 10);
    @(negedge clk);
    check("poke_res_held", bus.res, 32'd142);
    check("poke_no_restart", 32'(bus.busy), 32'd0);

    // Back-to-back: new start in the DONE cycle.
    @(negedge clk);
    issue(DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    wait_done("b2b_first", 34, 0);
    issue(DIV_OP_REMU, 32'd100, 32'd7, 32'd2);
    wait_done("b2b_second", 34, 0);

    // Reset in flight at cycle k+15.
    @(negedge clk);
    issue(DIV_OP_DIVU, 32'd999, 32'd3, 32'd333);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_res", bus.res, 32'd0);
    rst = 1'b0;
    void'(exp_q.pop_back());
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    run("after_rst", DIV_OP_DIVU, 32'd999, 32'd3, 32'd333);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      if (i % 2 == 0 && ra[0]) rb = -rb;
      run("random", rop, ra, rb, model(rop, ra, rb));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
